// File: rtl/heap_pkg.sv
// Shared types and constants for the heap memory and its arbiter.
package heap_pkg;

  localparam int unsigned HEAP_ADDR_WIDTH = 12;
  localparam int unsigned HEAP_DATA_WIDTH = 12;

  typedef logic [HEAP_ADDR_WIDTH-1:0] heap_addr_t;
  typedef logic [HEAP_DATA_WIDTH-1:0] heap_data_t;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module rr_picker #(
  parameter int unsigned NReq = 2,
  parameter int unsigned IdxW = $clog2(NReq)
) (
  input  logic [NReq-1:0] valid,
  input  logic [IdxW-1:0] last_grant,
  output logic [NReq-1:0] grant,
  output logic [IdxW-1:0] grant_idx,
  output logic            grant_any
);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    // Offset NReq wraps back to last_grant itself, so a lone requester can win again.
    for (int unsigned off = 1; off <= NReq; off++) begin
      cand = IdxW'((32'(last_grant) + off) % NReq);
      if (!grant_any && valid[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing the single-port heap memory, with a per-requester
// lock for read-modify-write sequences and a saturating stall counter.
module heap_arbiter
  import heap_pkg::*;
#(
  parameter int unsigned NReq       = 2,
  parameter int unsigned AddrWidth  = HEAP_ADDR_WIDTH,
  parameter int unsigned DataWidth  = HEAP_DATA_WIDTH,
  parameter int unsigned StallWidth = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NReq-1:0]           req_valid,
  output logic [NReq-1:0]           req_ready,
  input  logic [NReq-1:0]           req_write,
  input  logic [NReq-1:0]           req_lock,
  input  logic [NReq*AddrWidth-1:0] req_address,
  input  logic [NReq*DataWidth-1:0] req_data,
  output logic [NReq-1:0]           rsp_valid,
  output logic [DataWidth-1:0]      rsp_data,
  output logic                      heap_write,
  output logic [AddrWidth-1:0]      heap_address,
  output logic [DataWidth-1:0]      heap_in,
  input  logic [DataWidth-1:0]      heap_out,
  output logic [StallWidth-1:0]     stall_count
);

  localparam int unsigned IdxW = $clog2(NReq);

  arb_state_t            state_q, state_d;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [NReq-1:0]       rsp_valid_q;
  logic [StallWidth-1:0] stall_q, stall_d;

  logic [NReq-1:0] lock_mask, eligible, grant;
  logic [IdxW-1:0] grant_idx;
  logic            grant_any;
  logic            stall_event;

  always_comb begin
    lock_mask          = '0;
    lock_mask[owner_q] = 1'b1;
    eligible           = (state_q == LOCKED) ? (req_valid & lock_mask) : req_valid;
  end

  rr_picker #(
    .NReq (NReq),
    .IdxW (IdxW)
  ) u_picker (
    .valid      (eligible),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Heap port mux; zeros when idle so the memory performs a harmless read of address 0.
  always_comb begin
    heap_write   = 1'b0;
    heap_address = '0;
    heap_in      = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      if (grant[i]) begin
        heap_write   = req_write[i];
        heap_address = req_address[i*AddrWidth +: AddrWidth];
        heap_in      = req_data[i*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    if (grant_any) begin
      last_grant_d = grant_idx;
      if (req_lock[grant_idx]) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    stall_event = |(req_valid & ~grant);
    stall_d     = stall_q;
    if (stall_event && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IdxW'(NReq - 1);
      owner_q      <= '0;
      rsp_valid_q  <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rsp_valid_q  <= grant;
      stall_q      <= stall_d;
    end
  end

  assign req_ready   = grant;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = heap_out;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_heap_arbiter.sv
// Directed bench for heap_arbiter with a behavioural write-through heap memory.
module tb_heap_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid, req_write, req_lock;
  logic [11:0] addr0, addr1, data0, data1;
  logic [23:0] req_address;
  logic [23:0] req_data;

  logic [1:0]  req_ready, rsp_valid;
  logic [11:0] rsp_data, heap_address, heap_in, heap_out;
  logic        heap_write;
  logic [15:0] stall_count;

  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [11:0] s_rsp_data, s_heap_address, s_heap_in, s_heap_out;
  logic        s_heap_write;
  logic [3:0]  s_stall_count;

  logic [11:0] mem_a [4096];
  logic [11:0] mem_b [4096];

  int checks = 0;
  int errors = 0;

  assign req_address = {addr1, addr0};
  assign req_data    = {data1, data0};

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (heap_write) begin
      mem_a[heap_address] <= heap_in;
      heap_out            <= heap_in;
    end else begin
      heap_out <= mem_a[heap_address];
    end
  end

  always @(posedge clock) begin
    if (s_heap_write) begin
      mem_b[s_heap_address] <= s_heap_in;
      s_heap_out            <= s_heap_in;
    end else begin
      s_heap_out <= mem_b[s_heap_address];
    end
  end

  heap_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_lock     (req_lock),
    .req_address  (req_address),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .heap_write   (heap_write),
    .heap_address (heap_address),
    .heap_in      (heap_in),
    .heap_out     (heap_out),
    .stall_count  (stall_count)
  );

  heap_arbiter #(
    .StallWidth (4)
  ) dut_sat (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (s_req_ready),
    .req_write    (req_write),
    .req_lock     (req_lock),
    .req_address  (req_address),
    .req_data     (req_data),
    .rsp_valid    (s_rsp_valid),
    .rsp_data     (s_rsp_data),
    .heap_write   (s_heap_write),
    .heap_address (s_heap_address),
    .heap_in      (s_heap_in),
    .heap_out     (s_heap_out),
    .stall_count  (s_stall_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 2'b00;
    req_write = 2'b00;
    req_lock  = 2'b00;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (rsp_valid !== 2'b00) begin errors++;
      $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (stall_count !== 16'd0) begin errors++;
      $display("FAIL reset_stall: got %0d expected 0", stall_count); end
    checks++; if (s_stall_count !== 4'd0) begin errors++;
      $display("FAIL reset_sat_stall: got %0d expected 0", s_stall_count); end
    checks++; if (req_ready !== 2'b00) begin errors++;
      $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if ({heap_write, heap_address, heap_in} !== 25'd0) begin errors++;
      $display("FAIL reset_heap_idle: got w=%b a=%h d=%h expected 0/000/000",
               heap_write, heap_address, heap_in); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    req_valid = 2'b01; addr0 = 12'd5;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL read_ready: got %b expected 01", req_ready); end
    checks++; if (heap_address !== 12'd5 || heap_write !== 1'b0) begin errors++;
      $display("FAIL read_heap_port: got a=%h w=%b expected 005/0", heap_address, heap_write); end
    step();
    drive_idle();
    checks++; if (rsp_valid !== 2'b01) begin errors++;
      $display("FAIL read_rsp_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_data !== 12'h0A7) begin errors++;
      $display("FAIL read_rsp_data: got %h expected 0a7", rsp_data); end
    step();
    checks++; if (rsp_valid !== 2'b00) begin errors++;
      $display("FAIL read_rsp_once: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    req_valid = 2'b01; req_write = 2'b01; addr0 = 12'd3; data0 = 12'd2;
    #1;
    checks++; if (req_ready !== 2'b01 || heap_write !== 1'b1 || heap_in !== 12'd2) begin errors++;
      $display("FAIL b2b_write: got rdy=%b w=%b d=%h expected 01/1/002",
               req_ready, heap_write, heap_in); end
    step();
    req_write = 2'b00; data0 = '0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL b2b_second_grant: got %b expected 01", req_ready); end
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 12'd2) begin errors++;
      $display("FAIL b2b_write_rsp: got v=%b d=%h expected 01/002", rsp_valid, rsp_data); end
    step();
    drive_idle();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 12'd2) begin errors++;
      $display("FAIL b2b_read_rsp: got v=%b d=%h expected 01/002", rsp_valid, rsp_data); end
    checks++; if (stall_count !== 16'd0) begin errors++;
      $display("FAIL b2b_stall: got %0d expected 0", stall_count); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_order [4];
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    apply_reset();
    req_valid = 2'b11; addr0 = 12'd5; addr1 = 12'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== exp_order[i]) begin errors++;
        $display("FAIL contention_grant%0d: got %b expected %b", i, req_ready, exp_order[i]); end
      step();
    end
    drive_idle();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 12'd2) begin errors++;
      $display("FAIL contention_last_rsp: got v=%b d=%h expected 10/002", rsp_valid, rsp_data); end
    checks++; if (stall_count !== 16'd4) begin errors++;
      $display("FAIL contention_stall: got %0d expected 4", stall_count); end
  endtask

  task automatic test_lock();
    req_valid = 2'b01; addr0 = 12'd5;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL lock_pre_grant: got %b expected 01", req_ready); end
    step();
    req_valid = 2'b11; req_lock = 2'b10; addr1 = 12'd7;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++;
      $display("FAIL lock_take: got %b expected 10", req_ready); end
    step();
    req_valid = 2'b01; req_lock = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b00 || heap_write !== 1'b0 || heap_address !== 12'd0) begin
      errors++;
      $display("FAIL lock_owner_idle: got rdy=%b w=%b a=%h expected 00/0/000",
               req_ready, heap_write, heap_address); end
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 12'h111) begin errors++;
      $display("FAIL lock_read_rsp: got v=%b d=%h expected 10/111", rsp_valid, rsp_data); end
    step();
    req_valid = 2'b11; req_write = 2'b10; data1 = 12'h5A5;
    #1;
    checks++; if (req_ready !== 2'b10 || heap_in !== 12'h5A5) begin errors++;
      $display("FAIL lock_unlock_write: got rdy=%b d=%h expected 10/5a5", req_ready, heap_in); end
    step();
    req_valid = 2'b01; req_write = 2'b00; data1 = '0; addr0 = 12'd7;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL lock_release_grant: got %b expected 01", req_ready); end
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 12'h5A5) begin errors++;
      $display("FAIL lock_write_rsp: got v=%b d=%h expected 10/5a5", rsp_valid, rsp_data); end
    step();
    drive_idle();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 12'h5A5) begin errors++;
      $display("FAIL lock_raw_rsp: got v=%b d=%h expected 01/5a5", rsp_valid, rsp_data); end
    checks++; if (stall_count !== 16'd7) begin errors++;
      $display("FAIL lock_stall: got %0d expected 7", stall_count); end
  endtask

  task automatic test_reset_mid_lock();
    req_valid = 2'b01; req_lock = 2'b01; addr0 = 12'd5;
    step();
    checks++; if (rsp_valid !== 2'b01) begin errors++;
      $display("FAIL rml_pre_rsp: got %b expected 01", rsp_valid); end
    drive_idle();
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00 || stall_count !== 16'd0) begin errors++;
      $display("FAIL rml_async: got v=%b stall=%0d expected 00/0", rsp_valid, stall_count); end
    step();
    checks++; if (rsp_valid !== 2'b00 || stall_count !== 16'd0) begin errors++;
      $display("FAIL rml_held: got v=%b stall=%0d expected 00/0", rsp_valid, stall_count); end
    reset = 1'b0;
    req_valid = 2'b10; addr1 = 12'd3;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++;
      $display("FAIL rml_released: got %b expected 10", req_ready); end
    step();
    drive_idle();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 12'd2) begin errors++;
      $display("FAIL rml_rsp: got v=%b d=%h expected 10/002", rsp_valid, rsp_data); end
  endtask

  task automatic test_stall_saturation();
    apply_reset();
    req_valid = 2'b11; req_lock = 2'b01; addr0 = 12'd5; addr1 = 12'd3;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (i == 20) begin
        checks++; if (req_ready !== 2'b01 || s_req_ready !== 2'b01) begin errors++;
          $display("FAIL sat_lock_held: got %b/%b expected 01/01", req_ready, s_req_ready); end
      end
      step();
      if (i == 14) begin
        checks++; if (s_stall_count !== 4'd14) begin errors++;
          $display("FAIL sat_before_limit: got %0d expected 14", s_stall_count); end
      end
      if (i == 15) begin
        checks++; if (s_stall_count !== 4'd15) begin errors++;
          $display("FAIL sat_at_limit: got %0d expected 15", s_stall_count); end
      end
    end
    checks++; if (s_stall_count !== 4'd15) begin errors++;
      $display("FAIL sat_held: got %0d expected 15", s_stall_count); end
    checks++; if (stall_count !== 16'd20) begin errors++;
      $display("FAIL sat_wide_counter: got %0d expected 20", stall_count); end
    apply_reset();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[5] = 12'h0A7; mem_b[5] = 12'h0A7;
    mem_a[7] = 12'h111; mem_b[7] = 12'h111;
    drive_idle();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_contention();
    test_lock();
    test_reset_mid_lock();
    test_stall_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
